// File: rtl/freddie_dram_responder.sv
// freddie_dram_responder
//   Responder model of the DRAM array behind the Freddie strobe interface.
//   Samples ras/cas/w on every rising clk_in, detects their edges against
//   registered copies and acts on the same edge: latches the row on ras
//   fall and the column on cas fall, and performs early writes, late writes
//   and reads into a 2^(2*BA_W) x DATA_W array. A ras pulse with no cas is
//   treated as a RAS-only refresh. Strobe-protocol violations pulse
//   proto_err.
//
//   Optional feature macro: REFRESH_CHECK_EN
//     When defined, per-row age counters flag (sticky refresh_err) a read
//     of a row that has gone REFRESH_LIMIT cycles without being latched.
//     When undefined, refresh_err is constant 0.
//
//   Ports
//     clk_in      sampling clock, rising edge
//     rst         asynchronous reset, active low
//     ras/cas/w   row strobe, column strobe, write enable (all active low)
//     ba          multiplexed row/column address
//     din         write data
//     dout        read data (registered)
//     dout_oe     read data driven
//     row_q       last latched row
//     col_q       last latched column
//     proto_err   one-cycle pulse on protocol violation
//     refresh_err sticky stale-row flag
module freddie_dram_responder #(
    parameter int DATA_W        = 8,
    parameter int BA_W          = 8,
    parameter int TRP_MIN       = 2,
    parameter int REFRESH_LIMIT = 4096
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              ras,
    input  logic              cas,
    input  logic              w,
    input  logic [BA_W-1:0]   ba,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_oe,
    output logic [BA_W-1:0]   row_q,
    output logic [BA_W-1:0]   col_q,
    output logic              proto_err,
    output logic              refresh_err
);

    localparam int AW    = 2 * BA_W;
    localparam int DEPTH = 1 << AW;
    localparam int CNT_W = (TRP_MIN < 1) ? 1 : $clog2(TRP_MIN + 1);
    localparam logic [CNT_W-1:0] TRP_C = CNT_W'(TRP_MIN);

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_PRE} state_t;

    // The ras-rise edge itself counts as the first precharge edge, so a
    // TRP_MIN of 1 (or less) is met immediately.
    localparam state_t PRE_ENTRY = (TRP_MIN <= 1) ? S_IDLE : S_PRE;

    state_t           state_q;
    logic             ras_q, cas_q, w_q;
    logic [CNT_W-1:0] pre_cnt_q;
    logic [CNT_W-1:0] pre_cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic ras_fall, ras_rise, cas_fall, cas_rise, w_fall;
    assign ras_fall = ras_q & ~ras;
    assign ras_rise = ~ras_q & ras;
    assign cas_fall = cas_q & ~cas;
    assign cas_rise = ~cas_q & cas;
    assign w_fall   = w_q & ~w;

    assign pre_cnt_d = pre_cnt_q + CNT_W'(1);

    // Array access decode for the current edge.
    logic          we, rd_fire, row_latch;
    logic [AW-1:0] waddr;

    always_comb begin
        we        = 1'b0;
        rd_fire   = 1'b0;
        row_latch = 1'b0;
        waddr     = {row_q, ba};
        case (state_q)
            S_IDLE, S_PRE: row_latch = ras_fall;
            S_ROW: begin
                // ras rise wins over a coincident cas fall: no access.
                if (!ras_rise && cas_fall) begin
                    if (!w) we = 1'b1;
                    else    rd_fire = 1'b1;
                end
            end
            S_COL: begin
                // Late write needs the column strobe still asserted.
                if (w_fall && !cas) begin
                    we    = 1'b1;
                    waddr = {row_q, col_q};
                end
            end
            default: ;
        endcase
    end

    // Array contents are deliberately not reset. A reset edge leaves the
    // FSM in IDLE, which never raises we, so no write follows reset.
    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= din;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ras_q     <= 1'b1;
            cas_q     <= 1'b1;
            w_q       <= 1'b1;
            pre_cnt_q <= TRP_C;
            dout      <= '0;
            dout_oe   <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            proto_err <= 1'b0;
        end else begin
            ras_q     <= ras;
            cas_q     <= cas;
            w_q       <= w;
            proto_err <= 1'b0;

            // Read data is released on cas rise in any state, including
            // after ras has already gone high.
            if (cas_rise) dout_oe <= 1'b0;
            if (row_latch) row_q <= ba;
            if (rd_fire) begin
                dout    <= mem[{row_q, ba}];
                dout_oe <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    // cas fall with ras high, or together with ras fall,
                    // is a violation; the cas edge is then consumed.
                    proto_err <= cas_fall;
                    if (ras_fall) state_q <= S_ROW;
                end
                S_ROW: begin
                    if (ras_rise) begin
                        state_q   <= PRE_ENTRY;
                        pre_cnt_q <= CNT_W'(1);
                    end else if (cas_fall) begin
                        col_q   <= ba;
                        state_q <= S_COL;
                    end
                end
                S_COL: begin
                    if (we) dout_oe <= 1'b0;
                    if (ras_rise) begin
                        state_q   <= PRE_ENTRY;
                        pre_cnt_q <= CNT_W'(1);
                    end else if (cas_rise) begin
                        state_q <= S_ROW;
                    end
                end
                S_PRE: begin
                    if (ras_fall) begin
                        // Short precharge: flag it but let the access run.
                        proto_err <= 1'b1;
                        state_q   <= S_ROW;
                    end else if (pre_cnt_d >= TRP_C) begin
                        pre_cnt_q <= TRP_C;
                        state_q   <= S_IDLE;
                    end else begin
                        pre_cnt_q <= pre_cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef REFRESH_CHECK_EN
    localparam int ROWS  = 1 << BA_W;
    localparam int AGE_W = $clog2(REFRESH_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(REFRESH_LIMIT);

    logic [AGE_W-1:0] age_q [ROWS];
    logic             stale_q;
    logic             refresh_err_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROWS; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (row_latch && ba == BA_W'(i)) age_q[i] <= '0;
                else if (age_q[i] < AGE_LIM)     age_q[i] <= age_q[i] + AGE_W'(1);
            end
        end
    end

    // The latch itself clears the counter, so the row's age is captured
    // at the ras fall and judged when that row is read.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            stale_q       <= 1'b0;
            refresh_err_q <= 1'b0;
        end else begin
            if (row_latch) stale_q <= (age_q[ba] >= AGE_LIM);
            if (rd_fire && stale_q) refresh_err_q <= 1'b1;
        end
    end

    assign refresh_err = refresh_err_q;
`else
    // Feature not built; REFRESH_LIMIT is kept only so the parameter list
    // is identical in both builds.
    assign refresh_err = (REFRESH_LIMIT < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_freddie_dram_responder.sv
module tb_freddie_dram_responder;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       ras, cas, w;
    logic [7:0] ba, din;
    logic [7:0] dout, row_q, col_q;
    logic       dout_oe, proto_err, refresh_err;

    int vectors = 0;
    int miscompares = 0;

    freddie_dram_responder #(
        .DATA_W(8), .BA_W(8), .TRP_MIN(2), .REFRESH_LIMIT(16)
    ) dut (
        .clk_in(clk_in), .rst(rst), .ras(ras), .cas(cas), .w(w), .ba(ba),
        .din(din), .dout(dout), .dout_oe(dout_oe), .row_q(row_q),
        .col_q(col_q), .proto_err(proto_err), .refresh_err(refresh_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one set of pins, then step to 1 ns past the next rising edge.
    task automatic cyc(input logic r, input logic c, input logic wv,
                       input logic [7:0] a, input logic [7:0] d);
        ras = r; cas = c; w = wv; ba = a; din = d;
        @(posedge clk_in); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 1, 8'h00, 8'h00);
    endtask

    // Early write followed by the two precharge edges.
    task automatic wr_early(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
        cyc(0, 1, 1, r, 8'h00);
        cyc(0, 0, 0, c, d);
        cyc(0, 1, 1, c, 8'h00);
        idle(2);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] r, input logic [7:0] c,
                          input logic [7:0] exp);
        cyc(0, 1, 1, r, 8'h00);
        cyc(0, 0, 1, c, 8'h00);
        chk({tag, "_dout"}, dout, exp);
        chk({tag, "_oe"}, dout_oe, 1);
        cyc(0, 1, 1, c, 8'h00);
        chk({tag, "_oe_off"}, dout_oe, 0);
        idle(2);
    endtask

    initial begin
        rst = 1'b0; ras = 1; cas = 1; w = 1; ba = 0; din = 0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_oe", dout_oe, 0);
        chk("rst_row", row_q, 0);
        chk("rst_col", col_q, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_rerr", refresh_err, 0);
        @(negedge clk_in); rst = 1'b1;
        idle(2);

        // Early write 0x12/0x34 <- A5, then read back.
        cyc(0, 1, 1, 8'h12, 8'h00);
        chk("ew_row", row_q, 8'h12);
        chk("ew_perr", proto_err, 0);
        cyc(0, 0, 0, 8'h34, 8'hA5);
        chk("ew_col", col_q, 8'h34);
        chk("ew_oe", dout_oe, 0);
        cyc(0, 1, 1, 8'h34, 8'h00);
        idle(2);
        rd_chk("ew_rd", 8'h12, 8'h34, 8'hA5);

        // Late write 0x01/0x02 <- 5A.
        cyc(0, 1, 1, 8'h01, 8'h00);
        cyc(0, 0, 1, 8'h02, 8'h00);
        chk("lw_oe_rd", dout_oe, 1);
        cyc(0, 0, 0, 8'h02, 8'h5A);
        chk("lw_oe_drop", dout_oe, 0);
        cyc(0, 1, 0, 8'h02, 8'h00);
        idle(2);
        rd_chk("lw_rd", 8'h01, 8'h02, 8'h5A);

        // Page mode: three columns in one ras-low period.
        wr_early(8'h20, 8'h10, 8'h01);
        wr_early(8'h20, 8'h11, 8'h02);
        wr_early(8'h20, 8'h12, 8'h03);
        cyc(0, 1, 1, 8'h20, 8'h00);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] col, exp;
            col = 8'h10 + 8'(i);
            exp = 8'h01 + 8'(i);
            cyc(0, 0, 1, col, 8'h00);
            chk("pg_dout", dout, exp);
            chk("pg_row", row_q, 8'h20);
            cyc(0, 1, 1, col, 8'h00);
        end
        idle(2);

        // cas fall with ras high (w low, din FF): error pulse, no write.
        cyc(1, 0, 0, 8'h34, 8'hFF);
        chk("cbr_perr", proto_err, 1);
        cyc(1, 1, 1, 8'h00, 8'h00);
        chk("cbr_perr_off", proto_err, 0);
        idle(1);
        rd_chk("cbr_rd", 8'h12, 8'h34, 8'hA5);

        // Short precharge: RAS-only refresh of 0x12, ras re-falls after 1 edge.
        cyc(0, 1, 1, 8'h12, 8'h00);
        cyc(1, 1, 1, 8'h00, 8'h00);
        cyc(0, 1, 1, 8'h01, 8'h00);
        chk("trp_perr", proto_err, 1);
        chk("trp_row", row_q, 8'h01);
        cyc(0, 0, 1, 8'h02, 8'h00);
        chk("trp_dout", dout, 8'h5A);
        chk("trp_perr_off", proto_err, 0);
        cyc(0, 1, 1, 8'h02, 8'h00);
        idle(2);

        // Simultaneous ras/cas fall: row only, cas ignored until re-fall.
        cyc(0, 0, 1, 8'h12, 8'h00);
        chk("sim_perr", proto_err, 1);
        chk("sim_row", row_q, 8'h12);
        chk("sim_col", col_q, 8'h02);
        cyc(0, 0, 1, 8'h34, 8'h00);
        chk("sim_oe_hold", dout_oe, 0);
        cyc(0, 1, 1, 8'h34, 8'h00);
        cyc(0, 0, 1, 8'h34, 8'h00);
        chk("sim_dout", dout, 8'hA5);
        chk("sim_col2", col_q, 8'h34);
        cyc(0, 1, 1, 8'h34, 8'h00);
        idle(2);

        // Reset mid-access with w low before the write edge.
        wr_early(8'h30, 8'h40, 8'h11);
        cyc(0, 1, 1, 8'h30, 8'h00);
        cyc(0, 0, 1, 8'h40, 8'h00);
        chk("mr_oe_pre", dout_oe, 1);
        w = 0; din = 8'hEE; rst = 1'b0;
        #2;
        chk("mr_dout", dout, 0);
        chk("mr_oe", dout_oe, 0);
        chk("mr_row", row_q, 0);
        chk("mr_col", col_q, 0);
        @(posedge clk_in); #1;
        ras = 1; cas = 1; w = 1;
        @(negedge clk_in); rst = 1'b1;
        idle(2);
        rd_chk("mr_rd", 8'h30, 8'h40, 8'h11);

        // Stale row 0x07 (never latched): wait past the limit, then read.
        idle(20);
        cyc(0, 1, 1, 8'h07, 8'h00);
        cyc(0, 0, 1, 8'h00, 8'h00);
`ifdef REFRESH_CHECK_EN
        chk("ref_stale", refresh_err, 1);
`else
        chk("ref_stale", refresh_err, 0);
`endif
        cyc(0, 1, 1, 8'h00, 8'h00);
        idle(5);
`ifdef REFRESH_CHECK_EN
        chk("ref_sticky", refresh_err, 1);
`else
        chk("ref_sticky", refresh_err, 0);
`endif

        // Fresh start; RAS-only refresh of 0x07 every 10 cycles.
        @(negedge clk_in); rst = 1'b0;
        @(negedge clk_in); rst = 1'b1;
        #6;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 1, 8'h07, 8'h00);
            cyc(1, 1, 1, 8'h00, 8'h00);
            idle(8);
        end
        cyc(0, 1, 1, 8'h07, 8'h00);
        cyc(0, 0, 1, 8'h00, 8'h00);
        chk("ref_fresh", refresh_err, 0);
        cyc(0, 1, 1, 8'h00, 8'h00);
        idle(2);
        chk("ref_fresh_end", refresh_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/freddie_dram_responder.md
Name: freddie_dram_responder

Overview:
- Synthesizable responder model of the DRAM array at the far end of the Freddie strobe interface.
- Consumes ras, cas, w and the multiplexed ba bus.
- Latches row and column, performs early/late writes and reads into a 64K x 8 array, and honours RAS-only refresh.
- Flags strobe-protocol violations; serves as the bench partner for the Freddie generator.

Parameters:
- DATA_W, 8, data width of din/dout and of each array word.
- BA_W, 8, multiplexed address width; array depth is 2^(2*BA_W).
- TRP_MIN, 2, minimum clk_in rising edges ras must stay high (precharge) before the next ras fall.
- REFRESH_LIMIT, 4096, max clk_in cycles between refreshes of a row (used only with the optional feature).

Ports:
- clk_in  input  1  sampling clock, rising edge; reset rst is asynchronous, active-low; clock is clk_in.
- rst  input  1  asynchronous active-low reset.
- ras  input  1  row strobe, active low.
- cas  input  1  column strobe, active low.
- w  input  1  write enable, active low.
- ba  input  BA_W  multiplexed row/column address.
- din  input  DATA_W  write data.
- dout  output  DATA_W  read data.
- dout_oe  output  1  read data driven.
- row_q  output  BA_W  last latched row.
- col_q  output  BA_W  last latched column.
- proto_err  output  1  one-cycle pulse on protocol violation.
- refresh_err  output  1  sticky stale-row flag; tied 0 unless REFRESH_CHECK_EN.

Behaviour:
- Reset values: dout=0, dout_oe=0, row_q=0, col_q=0, proto_err=0, refresh_err=0. State=IDLE, ras_q=cas_q=w_q=1, precharge counter=TRP_MIN (satisfied). Array contents are not reset.
- Edge detection, every rising clk_in: compare the live ras/cas/w with their registered copies ras_q/cas_q/w_q. All actions take effect at that same edge (1-edge latency).
- IDLE (ras high, precharge met):
  - ras fall: row_q<=ba, go ROW.
  - cas fall: proto_err pulse, stay.
- ROW (ras low, cas high):
  - cas fall: col_q<=ba, go COL.
    - w low at that edge (early write): mem[{row_q,ba}]<=din, dout_oe stays 0.
    - w high (read): dout<=mem[{row_q,ba}], dout_oe<=1.
  - ras rise with no cas seen: RAS-only refresh of row_q, go PRE.
- COL (ras low, cas low):
  - w fall (late write): mem[{row_q,col_q}]<=din, dout_oe<=0.
  - cas rise: dout_oe<=0, go ROW (page mode allowed: a further cas fall latches a new column in the same row).
  - ras rise while cas low: go PRE; dout_oe holds until cas rises.
- PRE (ras high):
  - Counter increments each edge, saturating at TRP_MIN. Go IDLE when it reaches TRP_MIN.
  - ras fall before TRP_MIN: proto_err pulse, the row is still latched, go ROW (the access proceeds).
- Simultaneous ras fall and cas fall at one edge: proto_err pulse, latch row only, go ROW; the cas fall is ignored until cas rises and falls again.
- Any access that latches a row (read, write or refresh) counts as a refresh of that row.
- Reset asserted mid-access: all outputs and state return to reset values immediately. No partial write occurs after reset assertion.
- Address concatenation: row is the high half, column the low half; the index is 2*BA_W bits and does not wrap.

Optional Feature:
- Macro: REFRESH_CHECK_EN.
- Defined:
  - 2^BA_W per-row age counters increment each clk_in edge, saturating at REFRESH_LIMIT.
  - A row latch clears that row's counter.
  - A read of a row whose counter has reached REFRESH_LIMIT sets refresh_err sticky until reset. The data returned is unchanged.
- Not defined: no counters are built and refresh_err is constant 0.

Test Plan:
- Early write then read: ras fall with ba=0x12, cas fall with ba=0x34, w=0, din=0xA5. Then read cycle at 0x12/0x34 with w=1 -> dout=0xA5, dout_oe=1 at the cas-fall edge, dout_oe=0 at the cas-rise edge.
- Late write: row 0x01, col 0x02, cas fall with w=1, then w fall with din=0x5A -> dout_oe drops. Subsequent read of 0x0102 -> 0x5A.
- Page mode: one ras low period, three cas pulses with cols 0x10/0x11/0x12 reading preloaded 0x01/0x02/0x03 -> dout sequence 0x01,0x02,0x03, row_q constant.
- Protocol errors:
  - cas fall with ras high -> proto_err one cycle, no array change.
  - ras re-fall 1 edge after rise with TRP_MIN=2 -> proto_err, row still latched.
- Reset mid-write: rst low during COL with w low -> outputs zero. The target location retains its old value unless the write edge preceded reset.
- REFRESH_CHECK_EN, REFRESH_LIMIT=16: leave row 0x07 untouched 20 cycles, then read it -> refresh_err=1 and stays 1. With a RAS-only refresh of row 0x07 every 10 cycles -> refresh_err stays 0.
